imm_builder: RTL and testbench

IMM_BUILDER -- requirements
Module: imm_builder

---
 rtl/imm_builder_if.sv | 30 +++
 rtl/imm_builder.sv | 139 +++++++++++++
 tb/tb_imm_builder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/imm_builder_if.sv
// rtl/imm_builder_if.sv - beat input and word output handshake bundle for imm_builder
interface imm_builder_if #(
    parameter int IN_WIDTH   = 4,
    parameter int DATA_WIDTH = 8
) ();
    localparam int NBW = $clog2(DATA_WIDTH + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [IN_WIDTH-1:0]   in_data;
    logic                  in_last;
    logic                  in_sign;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [NBW-1:0]        out_nbits;
    logic                  out_ovf;

    // Producer of beats and consumer of words
    modport master (
        output in_valid, in_data, in_last, in_sign, out_ready,
        input  in_ready, out_valid, out_data, out_nbits, out_ovf
    );

    // The immediate builder itself
    modport slave (
        input  in_valid, in_data, in_last, in_sign, out_ready,
        output in_ready, out_valid, out_data, out_nbits, out_ovf
    );
endinterface

// File: rtl/imm_builder.sv
// rtl/imm_builder.sv - assembles MSB-first chunks into a sign/zero-extended immediate
module imm_builder #(
    parameter int IN_WIDTH   = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    imm_builder_if.slave bus
);
    localparam int MAX_BEATS_RAW = DATA_WIDTH / IN_WIDTH;
    localparam int MAX_BEATS     = (MAX_BEATS_RAW < 1) ? 1 : MAX_BEATS_RAW;
    localparam int CW            = $clog2(MAX_BEATS + 1);
    localparam int NBW           = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [NBW-1:0]        out_nbits_q, out_nbits_d;
    logic                  out_ovf_q, out_ovf_d;

    logic                  accept;
    logic                  stored;
    logic [DATA_WIDTH-1:0] acc_eff;
    logic [CW-1:0]         cnt_eff;
    logic                  ovf_eff;
    logic [NBW-1:0]        nbits_eff;
    logic [DATA_WIDTH-1:0] mask;
    logic                  sign_bit;
    logic [DATA_WIDTH-1:0] ext_word;

    assign bus.in_ready  = (state_q != HOLD);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = out_data_q;
    assign bus.out_nbits = out_nbits_q;
    assign bus.out_ovf   = out_ovf_q;

    assign accept = bus.in_valid && bus.in_ready;

    // Effective accumulator/count after the current beat; beats beyond capacity are dropped and flagged
    always_comb begin
        stored    = (count_q < MAX_CNT);
        acc_eff   = acc_q;
        cnt_eff   = count_q;
        ovf_eff   = ovf_q;
        if (stored) begin
            acc_eff = (acc_q << IN_WIDTH) | DATA_WIDTH'(bus.in_data);
            cnt_eff = count_q + CW'(1);
        end else begin
            ovf_eff = 1'b1;
        end
        nbits_eff = NBW'(int'(cnt_eff) * IN_WIDTH);
    end

    // Right-aligned extension: bits above nbits become zero or copies of bit nbits-1
    always_comb begin
        mask     = '0;
        sign_bit = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            mask[i] = (i < int'(nbits_eff));
            if (i == int'(nbits_eff) - 1) begin
                sign_bit = acc_eff[i];
            end
        end
        if (bus.in_sign && sign_bit) begin
            ext_word = (acc_eff & mask) | ~mask;
        end else begin
            ext_word = acc_eff & mask;
        end
    end

    // Next-state and datapath updates for the IDLE/ACCUM/HOLD sequencer
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        out_data_d  = out_data_q;
        out_nbits_d = out_nbits_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_d   = acc_eff;
                    count_d = cnt_eff;
                    ovf_d   = ovf_eff;
                    if (bus.in_last) begin
                        state_d     = HOLD;
                        out_data_d  = ext_word;
                        out_nbits_d = nbits_eff;
                        out_ovf_d   = ovf_eff;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any partial or pending word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_nbits_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            out_data_q  <= out_data_d;
            out_nbits_q <= out_nbits_d;
            out_ovf_q   <= out_ovf_d;
        end
    end
endmodule

// File: tb/tb_imm_builder.sv
// tb/tb_imm_builder.sv - directed self-checking bench for imm_builder (4-bit beats, 8-bit words)
module tb_imm_builder;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    imm_builder_if #(.IN_WIDTH(4), .DATA_WIDTH(8)) bif ();

    imm_builder #(.IN_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [3:0] data, input logic last, input logic sign);
        bif.in_valid = 1'b1;
        bif.in_data  = data;
        bif.in_last  = last;
        bif.in_sign  = sign;
        tick();
        bif.in_valid = 1'b0;
        bif.in_data  = 4'h0;
        bif.in_last  = 1'b0;
        bif.in_sign  = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [7:0] data,
                               input logic [3:0] nbits, input logic ovf);
        check_eq({tag, ".valid"}, 32'(bif.out_valid), 32'd1);
        check_eq({tag, ".ready"}, 32'(bif.in_ready), 32'd0);
        check_eq({tag, ".data"},  32'(bif.out_data), 32'(data));
        check_eq({tag, ".nbits"}, 32'(bif.out_nbits), 32'(nbits));
        check_eq({tag, ".ovf"},   32'(bif.out_ovf), 32'(ovf));
    endtask

    task automatic take_word(input string tag);
        bif.out_ready = 1'b1;
        tick();
        bif.out_ready = 1'b0;
        check_eq({tag, ".post_valid"}, 32'(bif.out_valid), 32'd0);
        check_eq({tag, ".post_ready"}, 32'(bif.in_ready), 32'd1);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bif.in_valid  = 1'b0;
        bif.in_data   = 4'h0;
        bif.in_last   = 1'b0;
        bif.in_sign   = 1'b0;
        bif.out_ready = 1'b0;

        tick();
        tick();
        check_eq("rst.valid", 32'(bif.out_valid), 32'd0);
        check_eq("rst.data",  32'(bif.out_data), 32'd0);
        check_eq("rst.nbits", 32'(bif.out_nbits), 32'd0);
        check_eq("rst.ovf",   32'(bif.out_ovf), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("rel.ready", 32'(bif.in_ready), 32'd1);

        // Beat presented without in_valid must be ignored
        bif.in_data = 4'hF;
        bif.in_last = 1'b1;
        tick();
        bif.in_last = 1'b0;
        check_eq("novalid.valid", 32'(bif.out_valid), 32'd0);

        send_beat(4'hA, 1'b1, 1'b1);
        expect_word("one_sx", 8'hFA, 4'd4, 1'b0);
        take_word("one_sx");

        send_beat(4'hA, 1'b1, 1'b0);
        expect_word("one_zx", 8'h0A, 4'd4, 1'b0);
        take_word("one_zx");

        send_beat(4'h8, 1'b0, 1'b0);
        check_eq("two.mid_valid", 32'(bif.out_valid), 32'd0);
        check_eq("two.mid_ready", 32'(bif.in_ready), 32'd1);
        send_beat(4'h3, 1'b1, 1'b1);
        expect_word("two_sx", 8'h83, 4'd8, 1'b0);
        take_word("two_sx");

        send_beat(4'h1, 1'b0, 1'b0);
        send_beat(4'h2, 1'b0, 1'b0);
        send_beat(4'h3, 1'b1, 1'b0);
        expect_word("ovf", 8'h12, 4'd8, 1'b1);
        take_word("ovf");

        // Sticky overflow must not leak into the following packet
        send_beat(4'h5, 1'b1, 1'b0);
        expect_word("after_ovf", 8'h05, 4'd4, 1'b0);
        take_word("after_ovf");

        send_beat(4'h3, 1'b1, 1'b1);
        expect_word("pos_sx", 8'h03, 4'd4, 1'b0);
        take_word("pos_sx");

        // Backpressure: pending word stays put while beats are offered
        send_beat(4'h9, 1'b1, 1'b1);
        expect_word("hold", 8'hF9, 4'd4, 1'b0);
        bif.in_valid = 1'b1;
        bif.in_data  = 4'hC;
        bif.in_last  = 1'b1;
        bif.in_sign  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_word($sformatf("hold%0d", i), 8'hF9, 4'd4, 1'b0);
        end
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
        take_word("hold");
        send_beat(4'h6, 1'b1, 1'b0);
        expect_word("after_hold", 8'h06, 4'd4, 1'b0);
        take_word("after_hold");

        // Reset in the middle of a packet drops the partial word
        send_beat(4'h7, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("mid_rst.valid", 32'(bif.out_valid), 32'd0);
        check_eq("mid_rst.data",  32'(bif.out_data), 32'd0);
        send_beat(4'h5, 1'b1, 1'b1);
        expect_word("after_rst", 8'h05, 4'd4, 1'b0);
        take_word("after_rst");

        // Reset while holding a word drops it without a handshake
        send_beat(4'hA, 1'b1, 1'b1);
        expect_word("hold_rst", 8'hFA, 4'd4, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("hold_rst.valid", 32'(bif.out_valid), 32'd0);
        check_eq("hold_rst.data",  32'(bif.out_data), 32'd0);
        check_eq("hold_rst.ready", 32'(bif.in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
